// File: rtl/inv_linear_map_stream.sv
// Inverse GF(2) linear byte map in a two-stage valid/ready pipeline with block framing.
// Define INV_LINEAR_MAP_CHECK_EN to add a forward-map self-check that drives check_err.
module inv_linear_map_stream #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       out_last,
  output logic [7:0] byte_cnt
`ifdef INV_LINEAR_MAP_CHECK_EN
  ,
  output logic       check_err
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(BLOCK_BYTES - 1);

  function automatic logic [7:0] inv_map(input logic [7:0] x);
    logic [7:0] y;
    y[0] = x[1] ^ x[4];
    y[1] = x[0] ^ x[1] ^ x[3] ^ x[5] ^ x[6] ^ x[7];
    y[2] = x[0] ^ x[2] ^ x[3] ^ x[5] ^ x[6] ^ x[7];
    y[3] = x[1] ^ x[6];
    y[4] = x[1] ^ x[2] ^ x[3] ^ x[4] ^ x[5] ^ x[6];
    y[5] = x[1] ^ x[4] ^ x[5] ^ x[7];
    y[6] = x[1] ^ x[5];
    y[7] = x[2];
    return y;
  endfunction

  logic       s1_valid;
  logic       s2_valid;
  logic [7:0] s1_data;
  logic [7:0] s2_data;
  logic       s2_adv;
  logic       s1_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  // Gating with rst_n keeps upstream from handshaking while the pipe is being cleared.
  assign in_ready  = rst_n && s1_adv;

  assign out_valid = s2_valid;
  assign data_out  = s2_data;
  assign out_last  = s2_valid && (byte_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= 8'h00;
      byte_cnt <= 8'h00;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= inv_map(s1_data);
        end
      end
      if (s2_valid && out_ready) begin
        byte_cnt <= (byte_cnt == LAST_IDX) ? 8'h00 : byte_cnt + 8'h01;
      end
    end
  end

  // Data register carries no reset; s1_valid alone decides whether it means anything.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_data <= data_in;
    end
  end

`ifdef INV_LINEAR_MAP_CHECK_EN
  function automatic logic [7:0] fwd_map(input logic [7:0] y);
    logic [7:0] x;
    x[0] = y[1] ^ y[4] ^ y[5] ^ y[6] ^ y[7];
    x[1] = y[1] ^ y[2] ^ y[7];
    x[2] = y[7];
    x[3] = y[0] ^ y[3] ^ y[4] ^ y[6] ^ y[7];
    x[4] = y[0] ^ y[1] ^ y[2] ^ y[7];
    x[5] = y[1] ^ y[2] ^ y[6] ^ y[7];
    x[6] = y[1] ^ y[2] ^ y[3] ^ y[7];
    x[7] = y[0] ^ y[1] ^ y[2] ^ y[5] ^ y[6] ^ y[7];
    return x;
  endfunction

  logic [7:0] s2_src;

  always_ff @(posedge clk) begin
    if (s2_adv && s1_valid) begin
      s2_src <= s1_data;
    end
  end

  // Sticky until reset so a single corrupted byte is never missed by slow polling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      check_err <= 1'b0;
    end else if (s2_valid && (fwd_map(s2_data) != s2_src)) begin
      check_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_inv_linear_map_stream.sv
// Self-checking bench for inv_linear_map_stream: directed vectors, backpressure, reset and random streams.
// Scoreboard model uses parity-mask tables derived from the map equations.
module tb_inv_linear_map_stream;

  localparam int BLOCK_BYTES = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic       out_last;
  logic [7:0] data_out;
  logic [7:0] byte_cnt;
`ifdef INV_LINEAR_MAP_CHECK_EN
  logic       check_err;
`endif

  inv_linear_map_stream #(.BLOCK_BYTES(BLOCK_BYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_last  (out_last),
    .byte_cnt  (byte_cnt)
`ifdef INV_LINEAR_MAP_CHECK_EN
    ,
    .check_err (check_err)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  int         exp_cnt = 0;
  int         acc_count = 0;
  int         last_seen = 0;
  logic       last_acc = 1'b0;
  logic       prev_stall = 1'b0;

  // Bit i of the result is the parity of the input under mask i.
  logic [7:0] inv_mask [8] = '{8'h12, 8'hEB, 8'hED, 8'h42, 8'h7E, 8'hB2, 8'h22, 8'h04};
  logic [7:0] fwd_mask [8] = '{8'hF2, 8'h86, 8'h80, 8'hD9, 8'h87, 8'hC6, 8'h8E, 8'hE7};

  function automatic logic [7:0] inv_model(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = ^(x & inv_mask[i]);
    return y;
  endfunction

  function automatic logic [7:0] fwd_model(input logic [7:0] y);
    logic [7:0] x;
    for (int i = 0; i < 8; i++) x[i] = ^(y & fwd_mask[i]);
    return x;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, score outputs, wait for the next falling edge.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy);
    in_valid  = iv;
    data_in   = d;
    out_ready = ordy;
    #1;
    last_acc = in_valid && in_ready;
    if (prev_stall) check_output("valid_held", out_valid, 1'b1);
    if (exp_q.size() == 0) begin
      check_output("no_output_pending", out_valid, 1'b0);
    end else if (out_valid) begin
      check_output("data_out", data_out, exp_q[0]);
      check_output("round_trip", fwd_model(data_out), src_q[0]);
      check_output("byte_cnt", byte_cnt, exp_cnt);
      check_output("out_last", out_last, exp_cnt == BLOCK_BYTES - 1);
      if (out_ready) begin
        void'(exp_q.pop_front());
        void'(src_q.pop_front());
        if (out_last) last_seen++;
        exp_cnt = (exp_cnt + 1) % BLOCK_BYTES;
      end
    end else begin
      check_output("out_last_idle", out_last, 1'b0);
    end
    if (last_acc) begin
      exp_q.push_back(inv_model(d));
      src_q.push_back(d);
      acc_count++;
    end
    prev_stall = out_valid && !out_ready;
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) cycle(1'b0, 8'h00, 1'b1);
    check_output("drain_empty", exp_q.size(), 0);
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    check_output("rst_in_ready", in_ready, 1'b0);
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_out_last", out_last, 1'b0);
    check_output("rst_data_out", data_out, 8'h00);
    check_output("rst_byte_cnt", byte_cnt, 8'h00);
`ifdef INV_LINEAR_MAP_CHECK_EN
    check_output("rst_check_err", check_err, 1'b0);
`endif
    rst_n = 1'b1;
    exp_q.delete();
    src_q.delete();
    exp_cnt = 0;
    prev_stall = 1'b0;
    #1;
    check_output("post_rst_in_ready", in_ready, 1'b1);
    check_output("post_rst_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] stall_bytes [3] = '{8'h3A, 8'hC5, 8'h7E};
    int idx;
    int acc0;
    int sent;
    int v;

    apply_reset(2);

    // Two-cycle latency for a single byte.
    cycle(1'b1, 8'h98, 1'b1);
    check_output("lat_c1_valid", out_valid, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check_output("lat_c2_valid", out_valid, 1'b1);
    check_output("lat_c2_data", data_out, 8'h01);
    check_output("lat_c2_cnt", byte_cnt, 8'h00);
    drain(8);

    // Back-to-back stream at full rate.
    cycle(1'b1, 8'hFF, 1'b1);
    cycle(1'b1, 8'hF3, 1'b1);
    check_output("b2b_0_data", data_out, 8'h80);
    cycle(1'b1, 8'h00, 1'b1);
    check_output("b2b_1_valid", out_valid, 1'b1);
    check_output("b2b_1_data", data_out, 8'h02);
    cycle(1'b0, 8'h00, 1'b1);
    check_output("b2b_2_valid", out_valid, 1'b1);
    check_output("b2b_2_data", data_out, 8'h00);
    drain(8);

    // Backpressure: five stalled cycles with three bytes offered.
    idx = 0;
    acc0 = acc_count;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, stall_bytes[idx], 1'b0);
      if (last_acc && idx < 2) idx++;
    end
    check_output("stall_accepted", acc_count - acc0, 2);
    in_valid = 1'b1;
    data_in = stall_bytes[idx];
    out_ready = 1'b0;
    #1;
    check_output("stall_in_ready", in_ready, 1'b0);
    check_output("stall_valid", out_valid, 1'b1);
    check_output("stall_data", data_out, inv_model(stall_bytes[0]));
    for (int c = 0; c < 10 && idx < 3; c++) begin
      cycle(1'b1, stall_bytes[idx], 1'b1);
      if (last_acc) idx++;
    end
    check_output("stall_all_sent", idx, 3);
    drain(10);

    // Reset with two bytes in flight.
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    apply_reset(1);
    cycle(1'b1, 8'h5C, 1'b1);
    drain(8);

    // Random 40-byte stream with random gaps and backpressure.
    apply_reset(1);
    last_seen = 0;
    sent = 0;
    for (int c = 0; c < 500 && sent < 40; c++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
      if (last_acc) sent++;
    end
    check_output("rand_sent", sent, 40);
    drain(200);
    check_output("rand_last_count", last_seen, 2);
    check_output("rand_cnt_end", byte_cnt, 8'd8);

    // All 256 byte values through the pipe and back through the forward map.
    v = 0;
    for (int c = 0; c < 3000 && v < 256; c++) begin
      cycle(1'b1, 8'(v), 1'($urandom_range(0, 1)));
      if (last_acc) v++;
    end
    check_output("exhaustive_sent", v, 256);
    drain(300);

`ifdef INV_LINEAR_MAP_CHECK_EN
    apply_reset(1);
    cycle(1'b1, 8'h98, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check_output("chk_clean", check_err, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    force dut.s2_data = 8'h03;
    @(negedge clk);
    check_output("chk_raised", check_err, 1'b1);
    release dut.s2_data;
    repeat (3) @(negedge clk);
    check_output("chk_sticky", check_err, 1'b1);
    apply_reset(1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_linear_map_stream.md
INV_LINEAR_MAP_STREAM -- requirements
Module: inv_linear_map_stream

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 16, meaning the number of bytes per block, which sets the out_last period (legal range 2..256).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning data_in holds a byte.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts data_in this cycle.
REQ-006 SHALL have port data_in, input, 8, mapped byte to be un-mapped.
REQ-007 SHALL have port out_valid, output, 1, meaning data_out is valid.
REQ-008 SHALL have port out_ready, input, 1, downstream accept.
REQ-009 SHALL have port data_out, output, 8, inverse-mapped byte.
REQ-010 SHALL have port out_last, output, 1, high with the final byte of each BLOCK_BYTES group.
REQ-011 SHALL have port byte_cnt, output, 8, index within the block of the byte presented on data_out.
REQ-012 SHALL have port check_err, output, 1, sticky self-check failure flag, present only under REQ-026.

Function
REQ-013 SHALL implement the exact GF(2) inverse of the forward linear map (x = data_in, y = data_out): y0=x1^x4; y1=x0^x1^x3^x5^x6^x7; y2=x0^x2^x3^x5^x6^x7; y3=x1^x6; y4=x1^x2^x3^x4^x5^x6; y5=x1^x4^x5^x7; y6=x1^x5; y7=x2.
REQ-014 SHALL use two register stages: S1 captures data_in, and S2 captures map(S1); data_out is driven from S2 registers only.
REQ-015 SHALL transfer a byte on an input handshake when in_valid&&in_ready, and on an output handshake when out_valid&&out_ready.
REQ-016 SHALL advance S2 when !s2_valid||out_ready, and SHALL advance S1 when !s1_valid||S2 advances; in_ready is defined as !s1_valid||S2 advances.
REQ-017 SHALL have a latency of 2 cycles from input handshake to out_valid when the pipe is empty, and SHALL sustain 1 byte/cycle when out_ready is held high.
REQ-018 SHALL hold data_out, out_last and byte_cnt stable while out_valid&&!out_ready, and SHALL not drop, duplicate or reorder bytes.
REQ-019 SHALL not deassert out_valid without an output handshake.
REQ-020 SHALL increment byte_cnt on each output handshake and wrap it from BLOCK_BYTES-1 to 0; out_last = out_valid&&(byte_cnt==BLOCK_BYTES-1).
REQ-021 SHALL, when an input and output handshake occur in the same cycle with a full pipe, shift both stages with no bubble.

Reset
REQ-022 SHALL, while rst_n=0 at a clk edge, clear s1_valid, s2_valid, byte_cnt and check_err to 0 and drive out_valid=0, out_last=0 and data_out=8'h00.
REQ-023 SHALL discard in-flight bytes on reset mid-operation; the first byte after reset has byte_cnt=0.
REQ-024 SHALL hold in_ready=0 during reset, which becomes 1 on the first cycle after rst_n returns high.
REQ-025 SHALL not reset the S1 data register, since only valid flags are required.

Configuration
REQ-026 SHALL compile in a self-check when INV_LINEAR_MAP_CHECK_EN is defined: re-apply the forward map to S2 data, compare the result to the S1 byte that produced it (held in a shadow register), and set check_err sticky on mismatch until reset.
REQ-027 SHALL, without INV_LINEAR_MAP_CHECK_EN, omit the check_err port, the shadow register and the forward-map logic, with all other behaviour identical.

Verification
REQ-028 SHALL verify that data_in=8'h98 with in_valid pulsed at cycle 0 and out_ready=1 gives out_valid at cycle 2, data_out=8'h01 and byte_cnt=0.
REQ-029 SHALL verify that the back-to-back stream 8'hFF, 8'hF3, 8'h00 with out_ready=1 gives 8'h80, 8'h02, 8'h00 on consecutive cycles.
REQ-030 SHALL verify that with out_ready=0 for 5 cycles and 3 bytes offered, at most 2 bytes are accepted, in_ready falls, data_out stays stable, and on release the bytes arrive in order with none lost.
REQ-031 SHALL verify that streaming 40 random bytes with BLOCK_BYTES=16 asserts out_last exactly on output bytes 16 and 32, wraps byte_cnt to 0, and exhaustively maps all 256 values through the forward map and back to the identity.
REQ-032 SHALL verify that asserting rst_n=0 for 1 cycle with 2 bytes in flight loses both bytes, gives out_valid=0 the next cycle, and gives byte_cnt=0 on the next output.
REQ-033 SHALL verify that with INV_LINEAR_MAP_CHECK_EN defined and S2 data forced to a wrong value, check_err rises and stays at 1 until rst_n=0.
